// File: rtl/s27_bist_driver.sv
// s27_bist_driver: built-in self-test driver for the s27 sequential core.
//
// Drives the core's primary inputs G0..G3 from a 4-bit LFSR (x^4+x^3+1), holds
// the core in reset for RST_CYCLES cycles, then applies NUM_PATTERNS patterns
// while compacting the core's G17 response into an 8-bit MISR
// (x^8+x^4+x^3+x^2+1). The final MISR is compared with GOLDEN_SIG.
//
// Ports:
//   clk_net        in   clock, rising edge
//   reset_net      in   synchronous active-high reset
//   start          in   one-cycle run request (ignored while busy)
//   g17_in         in   G17 response from the core
//   g0_out..g3_out out  core inputs G0..G3 (LFSR bits 0..3)
//   cut_reset_out  out  active-high reset to the core
//   busy           out  run in progress (RESET_CUT, RUN, COMPARE)
//   done           out  run finished; pass/signature/pattern_count hold
//   pass           out  signature compare result, valid while done
//   signature      out  current MISR contents
//   pattern_count  out  patterns applied in the current run
module s27_bist_driver #(
  parameter int unsigned NUM_PATTERNS = 15,
  parameter logic [3:0]  SEED         = 4'b0001,
  parameter int unsigned RST_CYCLES   = 2,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic       clk_net,
  input  logic       reset_net,
  input  logic       start,
  input  logic       g17_in,
  output logic       g0_out,
  output logic       g1_out,
  output logic       g2_out,
  output logic       g3_out,
  output logic       cut_reset_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] pattern_count
);

  typedef enum logic [2:0] {
    StIdle,
    StResetCut,
    StRun,
    StCompare,
    StDone
  } state_e;

  localparam logic [3:0] RstLast = 4'(RST_CYCLES - 1);
  localparam logic [7:0] PatLast = 8'(NUM_PATTERNS - 1);

  state_e     r_state;
  logic [3:0] r_lfsr;
  logic [7:0] r_misr;
  logic [7:0] r_cnt;
  logic [3:0] r_rst_cnt;
  logic       r_pass;

  state_e     w_state_next;
  logic [3:0] w_lfsr_next;
  logic [7:0] w_misr_next;
  logic [7:0] w_cnt_next;
  logic [3:0] w_rst_cnt_next;
  logic       w_pass_next;

  always_comb begin
    w_state_next   = r_state;
    w_lfsr_next    = r_lfsr;
    w_misr_next    = r_misr;
    w_cnt_next     = r_cnt;
    w_rst_cnt_next = r_rst_cnt;
    w_pass_next    = r_pass;

    unique case (r_state)
      StIdle, StDone: begin
        // Fresh init on start; from DONE this also clears the old result.
        if (start) begin
          w_state_next   = StResetCut;
          w_lfsr_next    = SEED;
          w_misr_next    = 8'h00;
          w_cnt_next     = 8'h00;
          w_rst_cnt_next = 4'h0;
          w_pass_next    = 1'b0;
        end
      end
      StResetCut: begin
        w_rst_cnt_next = r_rst_cnt + 4'h1;
        if (r_rst_cnt == RstLast) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        // g17_in here is the response to the pattern currently on r_lfsr.
        w_misr_next = {r_misr[6:0], 1'b0} ^ (r_misr[7] ? 8'h1D : 8'h00) ^ {7'b0, g17_in};
        w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        if (r_cnt != 8'hFF) begin
          w_cnt_next = r_cnt + 8'h01;
        end
        if (r_cnt == PatLast) begin
          w_state_next = StCompare;
        end
      end
      StCompare: begin
        w_pass_next  = (r_misr == GOLDEN_SIG);
        w_state_next = StDone;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_net) begin
    if (reset_net) begin
      r_state   <= StIdle;
      r_lfsr    <= SEED;
      r_misr    <= 8'h00;
      r_cnt     <= 8'h00;
      r_rst_cnt <= 4'h0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lfsr    <= w_lfsr_next;
      r_misr    <= w_misr_next;
      r_cnt     <= w_cnt_next;
      r_rst_cnt <= w_rst_cnt_next;
      r_pass    <= w_pass_next;
    end
  end

  assign g0_out        = r_lfsr[0];
  assign g1_out        = r_lfsr[1];
  assign g2_out        = r_lfsr[2];
  assign g3_out        = r_lfsr[3];
  assign cut_reset_out = (r_state == StResetCut);
  assign busy          = (r_state == StResetCut) || (r_state == StRun) ||
                         (r_state == StCompare);
  assign done          = (r_state == StDone);
  assign pass          = r_pass;
  assign signature     = r_misr;
  assign pattern_count = r_cnt;

endmodule

// File: tb/tb_s27_bist_driver.sv
// Directed bench for s27_bist_driver, including a closed loop with an s27 core model.
module tb_s27_bist_driver;

  logic       clk = 1'b0;
  logic       reset_net = 1'b1;
  logic       start = 1'b0;
  logic       g17_drv = 1'b0;
  logic       use_core = 1'b0;
  logic       g17_in;

  logic       g0, g1, g2, g3, cut_rst, busy, done, pass;
  logic [7:0] sig, pcnt;
  logic       gg0, gg1, gg2, gg3, gcut, gbusy, gdone, gpass;
  logic [7:0] gsig, gpcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s27_bist_driver dut (
    .clk_net(clk), .reset_net(reset_net), .start(start), .g17_in(g17_in),
    .g0_out(g0), .g1_out(g1), .g2_out(g2), .g3_out(g3), .cut_reset_out(cut_rst),
    .busy(busy), .done(done), .pass(pass), .signature(sig), .pattern_count(pcnt)
  );

  s27_bist_driver #(.GOLDEN_SIG(8'h13)) dut_g (
    .clk_net(clk), .reset_net(reset_net), .start(start), .g17_in(g17_in),
    .g0_out(gg0), .g1_out(gg1), .g2_out(gg2), .g3_out(gg3), .cut_reset_out(gcut),
    .busy(gbusy), .done(gdone), .pass(gpass), .signature(gsig), .pattern_count(gpcnt)
  );

  // s27 core model: returns {G17, next G5, next G6, next G7}.
  function automatic logic [3:0] s27_eval(input logic [3:0] gi, input logic [2:0] st);
    logic g5, g6, g7, g14, g12, g13, g8, g15, g16, g9, g11, g10;
    g5  = st[2];
    g6  = st[1];
    g7  = st[0];
    g14 = ~gi[0];
    g12 = ~(gi[1] | g7);
    g13 = ~(gi[2] | g12);
    g8  = g14 & g6;
    g15 = g12 | g8;
    g16 = gi[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    return {~g11, g10, g11, g13};
  endfunction

  logic [2:0] core_st = 3'b000;
  logic [3:0] core_res;
  assign core_res = s27_eval({g3, g2, g1, g0}, core_st);
  always @(posedge clk) begin
    if (cut_rst) core_st <= 3'b000;
    else         core_st <= core_res[2:0];
  end
  assign g17_in = use_core ? core_res[3] : g17_drv;

  logic [3:0] pat [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                           4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
                           4'b1000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start, check the fresh init, then step until done (bounded).
  task automatic do_run(input logic first_bit, input logic core_sel, input int pulse_at,
                        output int lat);
    use_core = core_sel;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    chk("init_done", 32'(done), 32'd0);
    chk("init_cut", 32'(cut_rst), 32'd1);
    chk("init_cnt", 32'(pcnt), 32'd0);
    chk("init_sig", 32'(sig), 32'd0);
    chk("init_pass", 32'(pass), 32'd0);
    while (!done && lat < 40) begin
      g17_drv = (lat == 3) ? first_bit : 1'b0;
      start = (lat == pulse_at);
      step();
      lat++;
    end
    start = 1'b0;
    g17_drv = 1'b0;
  endtask

  int lat;
  logic [7:0] ref_misr;
  logic [2:0] ref_st;
  logic [3:0] r;

  initial begin
    // Reset state.
    step();
    step();
    reset_net = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_cut", 32'(cut_rst), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_cnt", 32'(pcnt), 32'd0);
    chk("rst_g", 32'({g3, g2, g1, g0}), 32'h1);

    // Scenario 1: g17=0 constant, cycle-by-cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s1_cut1", 32'(cut_rst), 32'd1);
    chk("s1_busy1", 32'(busy), 32'd1);
    step();
    chk("s1_cut2", 32'(cut_rst), 32'd1);
    step();
    chk("s1_cut3", 32'(cut_rst), 32'd0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("s1_pat%0d", i), 32'({g3, g2, g1, g0}), 32'(pat[i]));
      chk($sformatf("s1_cnt%0d", i), 32'(pcnt), 32'(i));
      step();
    end
    chk("s1_done18", 32'(done), 32'd0);
    chk("s1_busy18", 32'(busy), 32'd1);
    step();
    chk("s1_done19", 32'(done), 32'd1);
    chk("s1_busy19", 32'(busy), 32'd0);
    chk("s1_sig", 32'(sig), 32'h00);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_cnt", 32'(pcnt), 32'd15);
    chk("s1_gwrap", 32'({g3, g2, g1, g0}), 32'h1);
    step();
    chk("s1_hold_done", 32'(done), 32'd1);
    chk("s1_hold_cnt", 32'(pcnt), 32'd15);

    // Scenario 2: g17=1 on first RUN cycle only.
    do_run(1'b1, 1'b0, -1, lat);
    chk("s2_lat", 32'(lat), 32'd19);
    chk("s2_sig", 32'(sig), 32'h13);
    chk("s2_pass", 32'(pass), 32'd0);
    chk("s2_gsig", 32'(gsig), 32'h13);
    chk("s2_gpass", 32'(gpass), 32'd1);

    // Scenario 3: reset during RUN cycle 7.
    start = 1'b1;
    step();
    start = 1'b0;
    g17_drv = 1'b1;
    repeat (8) step();
    chk("s3_pre_busy", 32'(busy), 32'd1);
    reset_net = 1'b1;
    step();
    reset_net = 1'b0;
    g17_drv = 1'b0;
    chk("s3_busy", 32'(busy), 32'd0);
    chk("s3_done", 32'(done), 32'd0);
    chk("s3_sig", 32'(sig), 32'h00);
    chk("s3_g", 32'({g3, g2, g1, g0}), 32'h1);
    chk("s3_cut", 32'(cut_rst), 32'd0);
    chk("s3_cnt", 32'(pcnt), 32'd0);
    step();
    chk("s3_idle_busy", 32'(busy), 32'd0);
    do_run(1'b0, 1'b0, -1, lat);
    chk("s3_rerun_lat", 32'(lat), 32'd19);
    chk("s3_rerun_sig", 32'(sig), 32'h00);
    chk("s3_rerun_pass", 32'(pass), 32'd1);

    // Scenario 4: start pulsed during RUN is ignored.
    do_run(1'b1, 1'b0, 8, lat);
    chk("s4_lat", 32'(lat), 32'd19);
    chk("s4_sig", 32'(sig), 32'h13);
    chk("s4_cnt", 32'(pcnt), 32'd15);

    // Scenario 5: restart from DONE gives an identical result.
    do_run(1'b1, 1'b0, -1, lat);
    chk("s5_lat", 32'(lat), 32'd19);
    chk("s5_sig", 32'(sig), 32'h13);
    chk("s5_pass", 32'(pass), 32'd0);

    // Scenario 6: closed loop with the s27 model; reference MISR from the pattern table.
    ref_misr = 8'h00;
    ref_st = 3'b000;
    for (int i = 0; i < 15; i++) begin
      r = s27_eval(pat[i], ref_st);
      ref_misr = {ref_misr[6:0], 1'b0} ^ (ref_misr[7] ? 8'h1D : 8'h00) ^ {7'b0, r[3]};
      ref_st = r[2:0];
    end
    do_run(1'b0, 1'b1, -1, lat);
    use_core = 1'b0;
    chk("s6_lat", 32'(lat), 32'd19);
    chk("s6_sig", 32'(sig), 32'(ref_misr));
    chk("s6_pass", 32'(pass), 32'(ref_misr == 8'h00));
    chk("s6_gpass", 32'(gpass), 32'(ref_misr == 8'h13));
    chk("s6_cnt", 32'(pcnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
